// File: rtl/id_decode_stage.sv
// id_decode_stage: registered MIPS32 instruction-decode stage.
// Decodes the IF/ID instruction word into a control bundle for EX, with
// stall/flush handling, a saturating illegal-instruction counter and a
// HALT latch that only reset clears.
// Optional feature: define MIPS_SPECIAL2_EN to decode opcode 011100
// (MUL, CLZ, CLO); without it that opcode is illegal.
module id_decode_stage #(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [31:0]          if_instr,
    input  logic [31:0]          if_pc,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 id_valid,
    output logic [31:0]          id_pc,
    output logic [2:0]           id_op_type,
    output logic [3:0]           id_alu_sel,
    output logic [4:0]           id_rs,
    output logic [4:0]           id_rt,
    output logic [4:0]           id_dest,
    output logic [4:0]           id_shamt,
    output logic [31:0]          id_imm,
    output logic                 id_reg_write,
    output logic                 id_mem_read,
    output logic                 id_mem_write,
    output logic                 id_branch_ne,
    output logic                 id_jump,
    output logic [31:0]          id_jump_target,
    output logic                 id_illegal,
    output logic [ILL_CNT_W-1:0] illegal_count,
    output logic                 halted
);

    localparam logic [2:0] OP_RRTYPE1 = 3'd1, OP_RRTYPE2 = 3'd2, OP_IRTYPE = 3'd3,
                           OP_LOAD = 3'd4, OP_STORE = 3'd5, OP_BRANCH = 3'd6, OP_HALT = 3'd7;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_NOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRA = 4'd7,
                           ALU_MOVN = 4'd8, ALU_MOVZ = 4'd9, ALU_DIV = 4'd10;
`ifdef MIPS_SPECIAL2_EN
    localparam logic [3:0] ALU_MUL = 4'd11, ALU_CLZ = 4'd12, ALU_CLO = 4'd13;
    localparam logic [5:0] F2_MUL = 6'b000010, F2_CLZ = 6'b100000, F2_CLO = 6'b100001;
`endif

    localparam logic [5:0] OPC_SPECIAL = 6'b000000, OPC_J = 6'b000010, OPC_BEQ = 6'b000100,
                           OPC_BNE = 6'b000101, OPC_ADDI = 6'b001000, OPC_SLTI = 6'b001010,
                           OPC_ANDI = 6'b001100, OPC_ORI = 6'b001101, OPC_SPECIAL2 = 6'b011100,
                           OPC_LW = 6'b100011, OPC_SW = 6'b101011, OPC_HALT = 6'b111111;

    localparam logic [5:0] F_SLL = 6'b000000, F_SRA = 6'b000011, F_MOVZ = 6'b001010,
                           F_MOVN = 6'b001011, F_DIV = 6'b011010, F_ADD = 6'b100000,
                           F_SUB = 6'b100010, F_AND = 6'b100100, F_OR = 6'b100101,
                           F_NOR = 6'b100111;

    typedef struct packed {
        logic [2:0]  op_type;
        logic [3:0]  alu_sel;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch_ne;
        logic        jump;
        logic        illegal;
    } ctrl_t;

    typedef enum logic {RUN, HALTED} state_t;

    state_t               state_q, state_d;
    ctrl_t                dec, ctrl_q;
    logic                 dec_halt;
    logic                 accept;
    logic [ILL_CNT_W-1:0] ill_cnt;

    logic [5:0]  opcode, funct;
    logic [31:0] sext, zext;
    assign opcode = if_instr[31:26];
    assign funct  = if_instr[5:0];
    assign sext   = {{16{if_instr[15]}}, if_instr[15:0]};
    assign zext   = {16'h0000, if_instr[15:0]};

    // Combinational decode of the offered instruction into a control bundle.
    always_comb begin
        dec      = '0;
        dec_halt = 1'b0;
        case (opcode)
            OPC_SPECIAL: begin
                dec.op_type   = OP_RRTYPE1;
                dec.dest      = if_instr[15:11];
                dec.reg_write = 1'b1;
                case (funct)
                    F_ADD:  dec.alu_sel = ALU_ADD;
                    F_SUB:  dec.alu_sel = ALU_SUB;
                    F_AND:  dec.alu_sel = ALU_AND;
                    F_OR:   dec.alu_sel = ALU_OR;
                    F_NOR:  dec.alu_sel = ALU_NOR;
                    F_MOVN: dec.alu_sel = ALU_MOVN;
                    F_MOVZ: dec.alu_sel = ALU_MOVZ;
                    F_DIV:  dec.alu_sel = ALU_DIV;
                    F_SLL:  begin dec.op_type = OP_RRTYPE2; dec.alu_sel = ALU_SLL; end
                    F_SRA:  begin dec.op_type = OP_RRTYPE2; dec.alu_sel = ALU_SRA; end
                    default: begin dec = '0; dec.illegal = 1'b1; end
                endcase
            end
            OPC_SPECIAL2: begin
`ifdef MIPS_SPECIAL2_EN
                dec.dest      = if_instr[15:11];
                dec.reg_write = 1'b1;
                case (funct)
                    F2_MUL: begin dec.op_type = OP_RRTYPE1; dec.alu_sel = ALU_MUL; end
                    F2_CLZ: begin dec.op_type = OP_RRTYPE2; dec.alu_sel = ALU_CLZ; end
                    F2_CLO: begin dec.op_type = OP_RRTYPE2; dec.alu_sel = ALU_CLO; end
                    default: begin dec = '0; dec.illegal = 1'b1; end
                endcase
`else
                dec.illegal = 1'b1;
`endif
            end
            OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI: begin
                dec.op_type   = OP_IRTYPE;
                dec.dest      = if_instr[20:16];
                dec.reg_write = 1'b1;
                case (opcode)
                    OPC_ADDI: begin dec.alu_sel = ALU_ADD; dec.imm = sext; end
                    OPC_SLTI: begin dec.alu_sel = ALU_SLT; dec.imm = sext; end
                    OPC_ANDI: begin dec.alu_sel = ALU_AND; dec.imm = zext; end
                    default:  begin dec.alu_sel = ALU_OR;  dec.imm = zext; end
                endcase
            end
            OPC_LW: begin
                dec.op_type   = OP_LOAD;
                dec.imm       = sext;
                dec.mem_read  = 1'b1;
                dec.dest      = if_instr[20:16];
                dec.reg_write = 1'b1;
            end
            OPC_SW: begin
                dec.op_type   = OP_STORE;
                dec.imm       = sext;
                dec.mem_write = 1'b1;
            end
            OPC_BEQ, OPC_BNE: begin
                dec.op_type   = OP_BRANCH;
                dec.alu_sel   = ALU_SUB;
                dec.imm       = {sext[29:0], 2'b00};
                dec.branch_ne = (opcode == OPC_BNE);
            end
            OPC_J: begin
                dec.op_type = OP_BRANCH;
                dec.jump    = 1'b1;
            end
            OPC_HALT: begin
                dec.op_type = OP_HALT;
                dec_halt    = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Accept qualification and RUN/HALTED next-state; HALTED is sticky.
    always_comb begin
        accept  = if_valid && !stall && !flush && (state_q == RUN);
        state_d = state_q;
        if (accept && dec_halt)
            state_d = HALTED;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Output bundle register: flush/idle insert a bubble, stall holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid       <= 1'b0;
            ctrl_q         <= '0;
            id_pc          <= '0;
            id_rs          <= '0;
            id_rt          <= '0;
            id_shamt       <= '0;
            id_jump_target <= '0;
            ill_cnt        <= '0;
        end else if (accept) begin
            id_valid       <= 1'b1;
            ctrl_q         <= dec;
            id_pc          <= if_pc;
            id_rs          <= if_instr[25:21];
            id_rt          <= if_instr[20:16];
            id_shamt       <= if_instr[10:6];
            id_jump_target <= {if_pc[31:28], if_instr[25:0], 2'b00};
            if (dec.illegal && (ill_cnt != {ILL_CNT_W{1'b1}}))
                ill_cnt <= ill_cnt + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
        end else if (flush || !stall) begin
            id_valid <= 1'b0;
            ctrl_q   <= '0;
        end
    end

    assign id_op_type    = ctrl_q.op_type;
    assign id_alu_sel    = ctrl_q.alu_sel;
    assign id_dest       = ctrl_q.dest;
    assign id_imm        = ctrl_q.imm;
    assign id_reg_write  = ctrl_q.reg_write;
    assign id_mem_read   = ctrl_q.mem_read;
    assign id_mem_write  = ctrl_q.mem_write;
    assign id_branch_ne  = ctrl_q.branch_ne;
    assign id_jump       = ctrl_q.jump;
    assign id_illegal    = ctrl_q.illegal;
    assign illegal_count = ill_cnt;
    assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_id_decode_stage.sv
// Testbench for id_decode_stage: directed scenarios plus randomized traffic
// checked against a mnemonic-level reference model.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, stall, flush;
    logic [31:0] if_instr, if_pc;
    logic        id_valid, id_reg_write, id_mem_read, id_mem_write, id_branch_ne, id_jump;
    logic        id_illegal, halted;
    logic [31:0] id_pc, id_imm, id_jump_target;
    logic [2:0]  id_op_type;
    logic [3:0]  id_alu_sel;
    logic [4:0]  id_rs, id_rt, id_dest, id_shamt;
    logic [7:0]  illegal_count;

    always #5 clk = ~clk;

    id_decode_stage #(.ILL_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .stall(stall), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
        .id_op_type(id_op_type), .id_alu_sel(id_alu_sel), .id_rs(id_rs), .id_rt(id_rt),
        .id_dest(id_dest), .id_shamt(id_shamt), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch_ne(id_branch_ne), .id_jump(id_jump),
        .id_jump_target(id_jump_target), .id_illegal(id_illegal),
        .illegal_count(illegal_count), .halted(halted)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  op;
        logic [3:0]  alu;
        logic [4:0]  rs, rt, dest, shamt;
        logic [31:0] imm;
        logic        rw, mr, mw, bne, j;
        logic [31:0] jt;
        logic        ill;
        logic [7:0]  cnt;
        logic        halted;
    } obs_t;

    typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_NOR, M_MOVN, M_MOVZ, M_DIV, M_SLL, M_SRA,
                  M_ADDI, M_SLTI, M_ANDI, M_ORI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_HALT,
                  M_MUL, M_CLZ, M_CLO, M_ILL} mn_t;

    obs_t obs, exp_q, msk;
    assign obs = {id_valid, id_pc, id_op_type, id_alu_sel, id_rs, id_rt, id_dest, id_shamt,
                  id_imm, id_reg_write, id_mem_read, id_mem_write, id_branch_ne, id_jump,
                  id_jump_target, id_illegal, illegal_count, halted};

    int vectors = 0;
    int miscompares = 0;

    // Fields that matter on a bubble; the rest are don't-care.
    function automatic obs_t bubble_mask();
        obs_t m = '0;
        m.valid = 1'b1; m.op = '1; m.rw = 1'b1; m.mr = 1'b1; m.mw = 1'b1;
        m.bne = 1'b1; m.j = 1'b1; m.ill = 1'b1; m.cnt = '1; m.halted = 1'b1;
        return m;
    endfunction

    function automatic mn_t classify(input logic [31:0] i);
        mn_t m = M_ILL;
        case (i[31:26])
            6'h00: case (i[5:0])
                       6'h20: m = M_ADD;  6'h22: m = M_SUB;  6'h24: m = M_AND;
                       6'h25: m = M_OR;   6'h27: m = M_NOR;  6'h0B: m = M_MOVN;
                       6'h0A: m = M_MOVZ; 6'h1A: m = M_DIV;  6'h00: m = M_SLL;
                       6'h03: m = M_SRA;  default: m = M_ILL;
                   endcase
`ifdef MIPS_SPECIAL2_EN
            6'h1C: case (i[5:0])
                       6'h02: m = M_MUL; 6'h20: m = M_CLZ; 6'h21: m = M_CLO;
                       default: m = M_ILL;
                   endcase
`endif
            6'h08: m = M_ADDI; 6'h0A: m = M_SLTI; 6'h0C: m = M_ANDI; 6'h0D: m = M_ORI;
            6'h23: m = M_LW;   6'h2B: m = M_SW;   6'h04: m = M_BEQ;  6'h05: m = M_BNE;
            6'h02: m = M_J;    6'h3F: m = M_HALT;
            default: m = M_ILL;
        endcase
        return m;
    endfunction

    // Expected bundle for an accepted instruction (cnt/halted filled by the caller).
    function automatic obs_t ref_bundle(input logic [31:0] i, input logic [31:0] pc);
        obs_t  r = '0;
        mn_t   m = classify(i);
        logic [31:0] sx = {{16{i[15]}}, i[15:0]};
        logic [31:0] zx = {16'h0, i[15:0]};
        r.valid = 1'b1; r.pc = pc; r.rs = i[25:21]; r.rt = i[20:16]; r.shamt = i[10:6];
        r.jt = {pc[31:28], i[25:0], 2'b00};
        case (m)
            M_ADD:  begin r.op = 3'd1; r.alu = 4'd0;  end
            M_SUB:  begin r.op = 3'd1; r.alu = 4'd1;  end
            M_AND:  begin r.op = 3'd1; r.alu = 4'd2;  end
            M_OR:   begin r.op = 3'd1; r.alu = 4'd3;  end
            M_NOR:  begin r.op = 3'd1; r.alu = 4'd4;  end
            M_MOVN: begin r.op = 3'd1; r.alu = 4'd8;  end
            M_MOVZ: begin r.op = 3'd1; r.alu = 4'd9;  end
            M_DIV:  begin r.op = 3'd1; r.alu = 4'd10; end
            M_MUL:  begin r.op = 3'd1; r.alu = 4'd11; end
            M_SLL:  begin r.op = 3'd2; r.alu = 4'd6;  end
            M_SRA:  begin r.op = 3'd2; r.alu = 4'd7;  end
            M_CLZ:  begin r.op = 3'd2; r.alu = 4'd12; end
            M_CLO:  begin r.op = 3'd2; r.alu = 4'd13; end
            M_ADDI: begin r.op = 3'd3; r.alu = 4'd0; r.imm = sx; end
            M_SLTI: begin r.op = 3'd3; r.alu = 4'd5; r.imm = sx; end
            M_ANDI: begin r.op = 3'd3; r.alu = 4'd2; r.imm = zx; end
            M_ORI:  begin r.op = 3'd3; r.alu = 4'd3; r.imm = zx; end
            M_LW:   begin r.op = 3'd4; r.imm = sx; r.mr = 1'b1; r.dest = i[20:16]; r.rw = 1'b1; end
            M_SW:   begin r.op = 3'd5; r.imm = sx; r.mw = 1'b1; end
            M_BEQ:  begin r.op = 3'd6; r.alu = 4'd1; r.imm = sx * 4; end
            M_BNE:  begin r.op = 3'd6; r.alu = 4'd1; r.imm = sx * 4; r.bne = 1'b1; end
            M_J:    begin r.op = 3'd6; r.j = 1'b1; end
            M_HALT: r.op = 3'd7;
            default: r.ill = 1'b1;
        endcase
        if (r.op inside {3'd1, 3'd2}) begin r.dest = i[15:11]; r.rw = 1'b1; end
        if (m inside {M_ADDI, M_SLTI, M_ANDI, M_ORI}) begin r.dest = i[20:16]; r.rw = 1'b1; end
        return r;
    endfunction

    // One clock with the given inputs; the model advances on the same edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fl);
        obs_t nxt;
        if_valid = v; if_instr = ins; if_pc = pc; stall = st; flush = fl;
        @(posedge clk);
        if (fl || (!st && (exp_q.halted || !v))) begin
            nxt = '0; nxt.cnt = exp_q.cnt; nxt.halted = exp_q.halted;
        end else if (st) begin
            nxt = exp_q;
        end else begin
            nxt = ref_bundle(ins, pc);
            nxt.cnt = (nxt.ill && exp_q.cnt != 8'd255) ? exp_q.cnt + 8'd1 : exp_q.cnt;
            nxt.halted = exp_q.halted || (classify(ins) == M_HALT);
        end
        exp_q = nxt;
        #1;
        msk = exp_q.valid ? '1 : bubble_mask();
    endtask

    task automatic apply_reset();
        #1 rst = 1'b1;
        #4;
        exp_q = '0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h00221820, 32'h10, 1'b0, 1'b0);
        if_valid = 1'b1; stall = 1'b1; flush = 1'b0;
        #1 rst = 1'b1;
        #2;
        vectors++;
        if (obs !== '0) begin miscompares++; $display("FAIL reset_async: got %h exp 0", obs); end
        @(posedge clk); #1 rst = 1'b0;
        exp_q = '0;
        vectors++;
        if (obs !== '0) begin miscompares++; $display("FAIL reset_hold: got %h exp 0", obs); end
    endtask

    task automatic test_add();
        apply_reset();
        drive(1'b1, 32'h00221820, 32'h0000_0040, 1'b0, 1'b0);
        vectors++;
        if ({id_valid, id_op_type, id_alu_sel, id_rs, id_rt, id_dest, id_reg_write} !==
            {1'b1, 3'd1, 4'd0, 5'd1, 5'd2, 5'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL add_fields: got v%b op%0d alu%0d rs%0d rt%0d d%0d rw%b", id_valid,
                     id_op_type, id_alu_sel, id_rs, id_rt, id_dest, id_reg_write);
        end
        vectors++;
        if ((obs & msk) !== (exp_q & msk)) begin
            miscompares++; $display("FAIL add_model: got %h exp %h", obs, exp_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [2] = '{32'h0000FFFF, 32'hFFFFFFFF};
        logic [31:0] ins  [2] = '{32'h3085FFFF, 32'h2085FFFF};
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, ins[k], 32'h200 + 32'(k * 4), 1'b0, 1'b0);
            vectors++;
            if (id_imm !== want[k] || id_valid !== 1'b1 || id_dest !== 5'd5) begin
                miscompares++;
                $display("FAIL b2b_imm%0d: got %h v%b d%0d exp %h", k, id_imm, id_valid, id_dest, want[k]);
            end
        end
    endtask

    task automatic test_branch_stall();
        obs_t snap;
        drive(1'b1, 32'h1485FFFF, 32'h0000_0100, 1'b0, 1'b0);
        vectors++;
        if (id_imm !== 32'hFFFFFFFC || id_branch_ne !== 1'b1 || id_op_type !== 3'd6) begin
            miscompares++;
            $display("FAIL bne_decode: got imm %h bne %b op %0d", id_imm, id_branch_ne, id_op_type);
        end
        snap = obs;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hF8000000, 32'h0000_0104, 1'b1, 1'b0);
            vectors++;
            if (obs !== snap) begin
                miscompares++; $display("FAIL stall_hold%0d: got %h exp %h", k, obs, snap);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if ((obs & msk) !== (exp_q & msk)) begin
            miscompares++; $display("FAIL idle_bubble: got %h exp %h", obs, exp_q);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        drive(1'b1, 32'hFC000000, 32'h300, 1'b0, 1'b1);
        vectors++;
        if (halted !== 1'b0 || id_valid !== 1'b0) begin
            miscompares++; $display("FAIL halt_flushed: got halted %b valid %b exp 0 0", halted, id_valid);
        end
        drive(1'b1, 32'hFC000000, 32'h300, 1'b0, 1'b0);
        vectors++;
        if (halted !== 1'b1 || id_valid !== 1'b1 || id_op_type !== 3'd7 || id_reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_bundle: got halted %b valid %b op %0d", halted, id_valid, id_op_type);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h00221820, 32'h304, 1'b0, 1'b0);
            vectors++;
            if (id_valid !== 1'b0 || halted !== 1'b1) begin
                miscompares++; $display("FAIL halted_idle%0d: got valid %b halted %b", k, id_valid, halted);
            end
        end
        apply_reset();
        vectors++;
        if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_reset: got %b exp 0", halted); end
    endtask

    task automatic test_illegal_sat();
        int want;
        apply_reset();
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, {6'h3E, 26'($urandom)}, 32'(k * 4), 1'b0, 1'b0);
            want = (k + 1 > 255) ? 255 : k + 1;
            vectors++;
            if (id_illegal !== 1'b1 || id_valid !== 1'b1 || id_op_type !== 3'd0 ||
                int'(illegal_count) != want) begin
                miscompares++;
                $display("FAIL illegal_sat%0d: got ill %b cnt %0d exp cnt %0d", k, id_illegal, illegal_count, want);
            end
        end
    endtask

    task automatic test_special2();
        apply_reset();
        drive(1'b1, 32'h70411002, 32'h400, 1'b0, 1'b0);
        vectors++;
`ifdef MIPS_SPECIAL2_EN
        if (id_op_type !== 3'd1 || id_alu_sel !== 4'd11 || id_dest !== 5'd2 || id_illegal !== 1'b0) begin
            miscompares++; $display("FAIL mul_decode: got op %0d alu %0d ill %b", id_op_type, id_alu_sel, id_illegal);
        end
`else
        if (id_illegal !== 1'b1 || illegal_count !== 8'd1 || id_op_type !== 3'd0) begin
            miscompares++; $display("FAIL mul_illegal: got ill %b cnt %0d", id_illegal, illegal_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0] opc [15] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A,
                                 6'h0C, 6'h0D, 6'h1C, 6'h23, 6'h2B, 6'h3E, 6'h00};
        logic [5:0] fn  [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h0B, 6'h0A, 6'h1A,
                                 6'h00, 6'h03, 6'h02, 6'h21, 6'h01, 6'h3F};
        logic [31:0] ins;
        apply_reset();
        for (int k = 0; k < 500; k++) begin
            ins = $urandom;
            ins[31:26] = opc[$urandom_range(14)];
            if ($urandom_range(3) != 0) ins[5:0] = fn[$urandom_range(13)];
            if (k == 250 && ins[31:26] != 6'h3F) ins = 32'h0;
            drive($urandom_range(9) < 8, ins, $urandom, $urandom_range(9) < 2, $urandom_range(9) < 1);
            vectors++;
            if ((obs & msk) !== (exp_q & msk)) begin
                miscompares++; $display("FAIL random%0d: instr %h got %h exp %h", k, ins, obs, exp_q);
            end
        end
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; stall = 1'b0; flush = 1'b0;
        exp_q = '0;
        #12 rst = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_branch_stall();
        test_halt();
        test_illegal_sat();
        test_special2();
        test_random();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
